one_hot_sequencer: RTL and testbench

//   Registered, parametrised binary-to-one-hot selector with a position register.

---
 rtl/one_hot_sequencer.sv | 152 +++++++++++++++
 tb/tb_one_hot_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/one_hot_sequencer.sv
// rtl/one_hot_sequencer.sv - registered one-hot selector with position register, stepping and auto-run
module one_hot_sequencer #(
   parameter  int WIDTH      = 8,
   parameter  int WRAP       = 1,
   parameter  int DWELL      = 4,
   localparam int ADDR_WIDTH = $clog2(WIDTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   input  logic                  i_load,
   input  logic [ADDR_WIDTH-1:0] iv_addr,
   input  logic                  i_step,
   input  logic                  i_dir,
   input  logic                  i_run,
   input  logic                  i_enable,
   output logic [WIDTH-1:0]      ov_output,
   output logic [ADDR_WIDTH-1:0] ov_addr,
   output logic                  o_valid,
   output logic                  o_wrap,
   output logic                  o_err
);

   // Dwell counter needs at least one bit even when DWELL is 1.
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_POS = ADDR_WIDTH'(WIDTH - 1);
   localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   state_t                  state_q, state_nx;
   logic [ADDR_WIDTH-1:0]   pos_q, pos_nx;
   logic [CNT_W-1:0]        cnt_q, cnt_nx;
   logic                    wrap_nx;
   logic                    err_nx;
   logic                    do_step;
   logic                    at_end;
   logic                    addr_ok;
   logic                    valid_nx;
   logic [WIDTH-1:0]        onehot_nx;

   // Loads beyond the lane count are rejected; compare against WIDTH, not 2**ADDR_WIDTH.
   assign addr_ok = (int'(iv_addr) < WIDTH);

   // Next state, position, dwell counter and event pulses, in clear > load > step/run priority.
   always_comb begin
      state_nx = state_q;
      pos_nx   = pos_q;
      cnt_nx   = cnt_q;
      wrap_nx  = 1'b0;
      err_nx   = 1'b0;
      do_step  = 1'b0;
      at_end   = 1'b0;

      if (i_clear) begin
         state_nx = ST_IDLE;
         pos_nx   = '0;
         cnt_nx   = '0;
      end else if (i_load) begin
         if (addr_ok) begin
            pos_nx   = iv_addr;
            cnt_nx   = '0;
            state_nx = i_run ? ST_RUN : ST_ACTIVE;
         end else begin
            err_nx = 1'b1;
         end
      end else begin
         case (state_q)
            ST_ACTIVE: begin
               if (i_run) begin
                  state_nx = ST_RUN;
                  cnt_nx   = '0;
               end else if (i_step) begin
                  do_step = 1'b1;
               end
            end
            ST_RUN: begin
               if (!i_run) begin
                  state_nx = ST_ACTIVE;
                  cnt_nx   = '0;
               end else if (cnt_q == LAST_CNT) begin
                  cnt_nx  = '0;
                  do_step = 1'b1;
               end else begin
                  cnt_nx = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_nx = ST_IDLE;
            end
         endcase
      end

      if (do_step) begin
         at_end = i_dir ? (pos_q == '0) : (pos_q == LAST_POS);
         if (at_end) begin
            wrap_nx = 1'b1;
            if (WRAP != 0) begin
               pos_nx = i_dir ? LAST_POS : '0;
            end else if (state_q == ST_RUN) begin
               state_nx = ST_ACTIVE;
            end
         end else begin
            pos_nx = i_dir ? (pos_q - ADDR_WIDTH'(1)) : (pos_q + ADDR_WIDTH'(1));
         end
      end
   end

   // Decode the upcoming position into the gated one-hot bus.
   always_comb begin
      valid_nx  = (state_nx != ST_IDLE);
      onehot_nx = '0;
      for (int k = 0; k < WIDTH; k++) begin
         onehot_nx[k] = valid_nx & i_enable & (pos_nx == ADDR_WIDTH'(k));
      end
   end

   // Sequencer state: FSM state, position and dwell counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         pos_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nx;
         pos_q   <= pos_nx;
         cnt_q   <= cnt_nx;
      end
   end

   // Output registers, one cycle after the causing edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ov_output <= '0;
         o_valid   <= 1'b0;
         o_wrap    <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         ov_output <= onehot_nx;
         o_valid   <= valid_nx;
         o_wrap    <= wrap_nx;
         o_err     <= err_nx;
      end
   end

   assign ov_addr = pos_q;

endmodule

// File: tb/tb_one_hot_sequencer.sv
// tb/tb_one_hot_sequencer.sv - directed self-checking bench for one_hot_sequencer
module tb_one_hot_sequencer;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       load;
   logic [2:0] addr;
   logic       step;
   logic       dir;
   logic       run;
   logic       enable;

   logic [7:0] a_out;  logic [2:0] a_addr;  logic a_valid, a_wrap, a_err;
   logic [7:0] s_out;  logic [2:0] s_addr;  logic s_valid, s_wrap, s_err;
   logic [4:0] f_out;  logic [2:0] f_addr;  logic f_valid, f_wrap, f_err;

   int vectors;
   int miscompares;

   // WIDTH=8 wrapping
   one_hot_sequencer #(.WIDTH(8), .WRAP(1), .DWELL(4)) u_wrap8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_load(load), .iv_addr(addr),
      .i_step(step), .i_dir(dir), .i_run(run), .i_enable(enable),
      .ov_output(a_out), .ov_addr(a_addr), .o_valid(a_valid), .o_wrap(a_wrap), .o_err(a_err));

   // WIDTH=8 saturating
   one_hot_sequencer #(.WIDTH(8), .WRAP(0), .DWELL(4)) u_sat8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_load(load), .iv_addr(addr),
      .i_step(step), .i_dir(dir), .i_run(run), .i_enable(enable),
      .ov_output(s_out), .ov_addr(s_addr), .o_valid(s_valid), .o_wrap(s_wrap), .o_err(s_err));

   // WIDTH=5 wrapping, non-power-of-two
   one_hot_sequencer #(.WIDTH(5), .WRAP(1), .DWELL(4)) u_wrap5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_load(load), .iv_addr(addr),
      .i_step(step), .i_dir(dir), .i_run(run), .i_enable(enable),
      .ov_output(f_out), .ov_addr(f_addr), .o_valid(f_valid), .o_wrap(f_wrap), .o_err(f_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0; clear = 1'b0; load = 1'b0; addr = 3'd0;
      step = 1'b0; dir = 1'b0; run = 1'b0; enable = 1'b1;
      tick(3);

      // reset state
      check("rst_out",   32'(a_out),   32'h00);
      check("rst_addr",  32'(a_addr),  32'd0);
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_wrap",  32'(a_wrap),  32'd0);
      check("rst_err",   32'(f_err),   32'd0);
      rst_n = 1'b1;
      tick(1);

      // load 5: valid on WIDTH=8, exactly WIDTH on WIDTH=5 -> rejected
      load = 1'b1; addr = 3'd5;
      tick(1);
      check("ld5_out",    32'(a_out),   32'h20);
      check("ld5_addr",   32'(a_addr),  32'd5);
      check("ld5_valid",  32'(a_valid), 32'd1);
      check("w5_ld5_err", 32'(f_err),   32'd1);
      check("w5_ld5_val", 32'(f_valid), 32'd0);
      check("w5_ld5_out", 32'(f_out),   32'h00);

      // load 7 then step up across the top
      addr = 3'd7;
      tick(1);
      check("ld7_out",   32'(a_out), 32'h80);
      check("sat_ld7",   32'(s_out), 32'h80);
      load = 1'b0; step = 1'b1; dir = 1'b0;
      tick(1);
      check("wrapup_addr", 32'(a_addr), 32'd0);
      check("wrapup_out",  32'(a_out),  32'h01);
      check("wrapup_pls",  32'(a_wrap), 32'd1);
      check("satup_addr",  32'(s_addr), 32'd7);
      check("satup_out",   32'(s_out),  32'h80);
      check("satup_pls",   32'(s_wrap), 32'd1);
      check("idle_step_v", 32'(f_valid), 32'd0);
      check("idle_step_w", 32'(f_wrap),  32'd0);
      step = 1'b0;
      tick(1);
      check("wrap_1cyc",  32'(a_wrap), 32'd0);
      check("sat_1cyc",   32'(s_wrap), 32'd0);

      // WIDTH=5: valid load 4, rejected load 6, then wrap both ways
      load = 1'b1; addr = 3'd4;
      tick(1);
      check("w5_ld4_out", 32'(f_out),   32'h10);
      check("w5_ld4_val", 32'(f_valid), 32'd1);
      addr = 3'd6;
      tick(1);
      check("w5_ld6_err",  32'(f_err),  32'd1);
      check("w5_ld6_out",  32'(f_out),  32'h10);
      check("w5_ld6_addr", 32'(f_addr), 32'd4);
      check("w8_ld6_addr", 32'(a_addr), 32'd6);
      load = 1'b0; step = 1'b1; dir = 1'b0;
      tick(1);
      check("w5_up_addr", 32'(f_addr), 32'd0);
      check("w5_up_out",  32'(f_out),  32'h01);
      check("w5_up_wrap", 32'(f_wrap), 32'd1);
      check("w5_err_1cy", 32'(f_err),  32'd0);
      check("w8_up_addr", 32'(a_addr), 32'd7);
      check("w8_up_wrap", 32'(a_wrap), 32'd0);
      dir = 1'b1;
      tick(1);
      check("w5_dn_addr", 32'(f_addr), 32'd4);
      check("w5_dn_wrap", 32'(f_wrap), 32'd1);
      check("w8_dn_addr", 32'(a_addr), 32'd6);
      step = 1'b0;

      // RUN from position 2, down, dwell 4
      load = 1'b1; addr = 3'd2; run = 1'b1;
      tick(1);
      load = 1'b0;
      check("run_ld_addr", 32'(f_addr), 32'd2);
      tick(3);
      check("run_dwell",   32'(f_addr), 32'd2);
      tick(1);
      check("run_p1",      32'(f_addr), 32'd1);
      check("run_p1_out",  32'(f_out),  32'h02);
      check("run_p1_wrap", 32'(f_wrap), 32'd0);
      enable = 1'b0;
      tick(3);
      check("gate_out",    32'(f_out),  32'h00);
      check("gate_addr",   32'(f_addr), 32'd1);
      tick(1);
      check("gate_p0",     32'(f_addr), 32'd0);
      check("gate_p0_out", 32'(f_out),  32'h00);
      check("gate_p0_val", 32'(f_valid), 32'd1);
      check("gate_w8_out", 32'(a_out),  32'h00);
      check("sat_p0_addr", 32'(s_addr), 32'd0);
      enable = 1'b1;
      tick(1);
      check("ungate_out",  32'(f_out),  32'h01);
      check("ungate_w8",   32'(a_out),  32'h01);
      tick(2);
      check("run_pre4",    32'(f_addr), 32'd0);
      tick(1);
      check("run_p4",      32'(f_addr), 32'd4);
      check("run_p4_out",  32'(f_out),  32'h10);
      check("run_p4_wrap", 32'(f_wrap), 32'd1);
      check("w8_run_p7",   32'(a_addr), 32'd7);
      check("w8_run_wrap", 32'(a_wrap), 32'd1);
      check("sat_blk_addr", 32'(s_addr), 32'd0);
      check("sat_blk_wrap", 32'(s_wrap), 32'd1);
      check("sat_blk_val",  32'(s_valid), 32'd1);
      tick(1);
      check("run_wrap_1cy", 32'(f_wrap), 32'd0);
      tick(2);

      // asynchronous reset mid-RUN
      rst_n = 1'b0;
      #1;
      check("arst_out",   32'(f_out),   32'h00);
      check("arst_addr",  32'(f_addr),  32'd0);
      check("arst_valid", 32'(f_valid), 32'd0);
      check("arst_w8out", 32'(a_out),   32'h00);
      run = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // clear beats a simultaneous load
      load = 1'b1; addr = 3'd3;
      tick(1);
      check("ld3_addr",  32'(a_addr),  32'd3);
      check("ld3_valid", 32'(a_valid), 32'd1);
      clear = 1'b1; addr = 3'd6;
      tick(1);
      check("clr_valid", 32'(a_valid), 32'd0);
      check("clr_addr",  32'(a_addr),  32'd0);
      check("clr_out",   32'(a_out),   32'h00);
      check("clr_w5err", 32'(f_err),   32'd0);
      clear = 1'b0; load = 1'b0; step = 1'b1; dir = 1'b0;
      tick(1);
      check("idle_step_val",  32'(a_valid), 32'd0);
      check("idle_step_addr", 32'(a_addr),  32'd0);
      step = 1'b0;
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
